nvdla_cdp_dp_intp_arb: RTL and testbench
========================================

Name: nvdla_cdp_dp_intp_arb

Overview:
- Round-robin arbiter that shares one CDP interpolation datapath unit (3-stage, in-order, valid/ready) between NUM_REQ requesters.
- Muxes the granted requester's operands onto the unit input.
- Records the requester ID in a tag FIFO.
- Steers each unit result back to its originating requester.
- Sits between the CDP interpolation front-end lanes and the shared INTP unit instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
REQ_W, 2, requester ID width, equal to clog2(NUM_REQ)
TAG_DEPTH, 4, tag FIFO entries; must be at least 4 (unit pipeline depth 3 plus 1)

Ports:
nvdla_core_clk  input  1  core clock
nvdla_core_rstn  input  1  asynchronous active-low reset
req_vld  input  NUM_REQ  per-requester operand valid
req_rdy  output  NUM_REQ  per-requester operand accept
req_in0_pd  input  NUM_REQ*39  X0 extended operand, requester i at [39i+38:39i]
req_in1_pd  input  NUM_REQ*38  X1 extended operand
req_in_pd  input  NUM_REQ*17  X0 base value
req_in_scale  input  NUM_REQ*17  fractional scale
req_in_shift  input  NUM_REQ*6  signed shift
intp_in_vld  output  1  to unit
intp_in_rdy  input  1  from unit
intp_in0_pd  output  39  to unit
intp_in1_pd  output  38  to unit
intp_in_pd  output  17  to unit
intp_in_scale  output  17  to unit
intp_in_shift  output  6  to unit
intp_out_vld  input  1  result valid from unit
intp_out_rdy  output  1  result accept to unit
intp_out_pd  input  17  result from unit
resp_vld  output  NUM_REQ  per-requester result valid
resp_rdy  input  NUM_REQ  per-requester result accept
resp_pd  output  17  result data, broadcast to all requesters
arb_idle  output  1  no requests pending and tag FIFO empty
arb_err  output  1  sticky: unit result arrived with tag FIFO empty

Behaviour:
- Clock and reset: one clock, nvdla_core_clk. Reset nvdla_core_rstn is asynchronous, active-low. All state clears on reset assertion.
- Reset values: RR pointer 0; FIFO empty (wr_ptr = rd_ptr = 0, count = 0); arb_err 0. Consequently req_rdy = 0, intp_in_vld = 0, resp_vld = 0, intp_out_rdy = 0, arb_idle = 1. Data outputs are don't-care but driven deterministically; the mux selects requester 0 when nothing is granted.
- Arbitration is combinational and adds 0 cycles:
  - Grant goes to the lowest index j = (ptr + k) mod NUM_REQ, k = 0..NUM_REQ-1, with req_vld[j] = 1.
  - intp_in_vld = |req_vld & ~fifo_full.
  - req_rdy[i] = gnt[i] & intp_in_rdy & ~fifo_full.
  - The operand mux selects gnt.
- Issue: issue = intp_in_vld & intp_in_rdy. On issue:
  - push the grant ID into the FIFO;
  - ptr <= gnt_id + 1 mod NUM_REQ.
  - No issue means ptr holds.
- Grant may change while intp_in_rdy = 0. A requester holds valid/data until it sees req_rdy. The arbiter provides no grant lock.
- FIFO full: intp_in_vld forced 0, all req_rdy 0. No push when full, even if a pop occurs in the same cycle.
- Return path, with head = FIFO head ID:
  - resp_vld[i] = intp_out_vld & ~fifo_empty & (head == i);
  - intp_out_rdy = ~fifo_empty & resp_rdy[head];
  - resp_pd = intp_out_pd.
  - Pop when intp_out_vld & intp_out_rdy.
- Simultaneous push and pop (not full) leaves count unchanged; both pointers advance and wrap modulo TAG_DEPTH.
- A requester that deasserts resp_rdy stalls the unit output, and back-pressure propagates. Results are strictly in issue order.
- Error case, intp_out_vld = 1 with FIFO empty:
  - arb_err <= 1 (sticky until reset);
  - intp_out_rdy = 0;
  - no pop occurs.
- arb_idle = ~|req_vld & fifo_empty.
- Reset mid-operation discards in-flight tags. The unit shares the same reset, so no orphan results are produced.

Decomposition:
- Shared package holds: CDP_INTP_IN0_W=39, IN1_W=38, PD_W=17, SCALE_W=17, SHIFT_W=6, and the requester-ID typedef.
- One sub-module, nvdla_cdp_intp_tag_fifo: flop-based FIFO, TAG_DEPTH x REQ_W, with push/pop/full/empty/head.
- Round-robin arbiter logic is inline.

Test Plan:
1. Reset, then all req_vld = 0 -> arb_idle = 1, intp_in_vld = 0, resp_vld = 0, arb_err = 0.
2. All 4 requesters valid continuously, unit and resp_rdy always ready -> grants 0,1,2,3,0,...; results return to 0,1,2,3 in order with intp_out_pd matching the issued operands (e.g. in_pd=0x00100, in0=0, in1=0x100, scale=0x8000, shift=16 -> resp_pd=0x00180).
3. Only requester 2 valid, then requester 1 joins -> grant 2, pointer moves to 3, next grant 1; no starvation over 100 random cycles.
4. resp_rdy[head] = 0 for 10 cycles with continuous requests -> FIFO fills to 4, req_rdy all 0; releasing resp_rdy drains results in order with no loss or duplication.
5. Push and pop in the same cycle at count = 3 -> count stays 3 and pointers wrap correctly across 20 iterations.
6. Force intp_out_vld = 1 with FIFO empty -> arb_err = 1, intp_out_rdy = 0; arb_err stays 1 until nvdla_core_rstn = 0, then clears.

Source files
------------

// File: rtl/nvdla_cdp_dp_intp_arb_pkg.sv
// Shared definitions for the CDP interpolation arbiter slice.
// Holds the operand and result widths of the shared INTP unit, the default
// requester count, and the requester-ID type.
package nvdla_cdp_dp_intp_arb_pkg;

    localparam int CDP_INTP_IN0_W   = 39;
    localparam int CDP_INTP_IN1_W   = 38;
    localparam int CDP_INTP_PD_W    = 17;
    localparam int CDP_INTP_SCALE_W = 17;
    localparam int CDP_INTP_SHIFT_W = 6;

    localparam int CDP_INTP_NUM_REQ = 4;
    localparam int CDP_INTP_REQ_W   = 2;

    typedef logic [CDP_INTP_REQ_W-1:0] cdp_intp_req_id_t;

endpackage

// File: rtl/nvdla_cdp_intp_tag_fifo.sv
// Flop-based tag FIFO that remembers which requester owns each operand
// currently inside the shared INTP unit.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   push, push_data                  : write a tag (ignored while full)
//   pop                              : drop the head tag (ignored while empty)
//   full, empty                      : occupancy flags
//   head                             : oldest tag
module nvdla_cdp_intp_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped even if a pop happens in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointer wrap is explicit so DEPTH need not be a power of two.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Tag storage is cleared on reset so the head output is deterministic.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/nvdla_cdp_dp_intp_arb.sv
// Round-robin arbiter sharing one 3-stage in-order CDP INTP unit between
// NUM_REQ front-end lanes. The granted lane's operands are muxed onto the
// unit input, its ID is queued in a tag FIFO, and each unit result is
// steered back to the lane at the FIFO head.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn  : clock, async active-low reset
//   req_vld/req_rdy, req_in*          : per-lane operand handshake and data
//   intp_in_vld/rdy, intp_in*         : operand channel to the unit
//   intp_out_vld/rdy, intp_out_pd     : result channel from the unit
//   resp_vld/resp_rdy, resp_pd        : per-lane result handshake, shared data
//   arb_idle                          : no requests and no results owed
//   arb_err                           : sticky, result arrived with no tag
module nvdla_cdp_dp_intp_arb
    import nvdla_cdp_dp_intp_arb_pkg::*;
#(
    parameter int NUM_REQ   = CDP_INTP_NUM_REQ,
    parameter int REQ_W     = CDP_INTP_REQ_W,
    parameter int TAG_DEPTH = 4
) (
    input  logic                                 nvdla_core_clk,
    input  logic                                 nvdla_core_rstn,
    input  logic [NUM_REQ-1:0]                   req_vld,
    output logic [NUM_REQ-1:0]                   req_rdy,
    input  logic [NUM_REQ*CDP_INTP_IN0_W-1:0]    req_in0_pd,
    input  logic [NUM_REQ*CDP_INTP_IN1_W-1:0]    req_in1_pd,
    input  logic [NUM_REQ*CDP_INTP_PD_W-1:0]     req_in_pd,
    input  logic [NUM_REQ*CDP_INTP_SCALE_W-1:0]  req_in_scale,
    input  logic [NUM_REQ*CDP_INTP_SHIFT_W-1:0]  req_in_shift,
    output logic                                 intp_in_vld,
    input  logic                                 intp_in_rdy,
    output logic [CDP_INTP_IN0_W-1:0]            intp_in0_pd,
    output logic [CDP_INTP_IN1_W-1:0]            intp_in1_pd,
    output logic [CDP_INTP_PD_W-1:0]             intp_in_pd,
    output logic [CDP_INTP_SCALE_W-1:0]          intp_in_scale,
    output logic [CDP_INTP_SHIFT_W-1:0]          intp_in_shift,
    input  logic                                 intp_out_vld,
    output logic                                 intp_out_rdy,
    input  logic [CDP_INTP_PD_W-1:0]             intp_out_pd,
    output logic [NUM_REQ-1:0]                   resp_vld,
    input  logic [NUM_REQ-1:0]                   resp_rdy,
    output logic [CDP_INTP_PD_W-1:0]             resp_pd,
    output logic                                 arb_idle,
    output logic                                 arb_err
);

    logic [REQ_W-1:0] rr_ptr;
    logic [REQ_W-1:0] gnt_id;
    logic             gnt_found;
    logic [REQ_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             issue;
    logic             pop;

    // Search starts at the round-robin pointer; the first valid lane wins.
    // gnt_id stays 0 when nobody requests so the operand mux is deterministic.
    always_comb begin
        logic [REQ_W-1:0] cand;
        gnt_id    = '0;
        gnt_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = REQ_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_found && req_vld[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    assign intp_in_vld = (|req_vld) & ~fifo_full;
    assign issue       = intp_in_vld & intp_in_rdy;

    // Only the granted lane sees ready, and only when the unit and tag FIFO
    // can both take the operand.
    always_comb begin
        req_rdy = '0;
        if (gnt_found && intp_in_rdy && !fifo_full) begin
            req_rdy[gnt_id] = 1'b1;
        end
    end

    // Operand mux onto the shared unit input.
    always_comb begin
        intp_in0_pd   = req_in0_pd[int'(gnt_id)*CDP_INTP_IN0_W +: CDP_INTP_IN0_W];
        intp_in1_pd   = req_in1_pd[int'(gnt_id)*CDP_INTP_IN1_W +: CDP_INTP_IN1_W];
        intp_in_pd    = req_in_pd[int'(gnt_id)*CDP_INTP_PD_W +: CDP_INTP_PD_W];
        intp_in_scale = req_in_scale[int'(gnt_id)*CDP_INTP_SCALE_W +: CDP_INTP_SCALE_W];
        intp_in_shift = req_in_shift[int'(gnt_id)*CDP_INTP_SHIFT_W +: CDP_INTP_SHIFT_W];
    end

    // The pointer moves just past the lane that was served; it holds otherwise.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (gnt_id == REQ_W'(NUM_REQ - 1)) ? '0 : gnt_id + REQ_W'(1);
        end
    end

    nvdla_cdp_intp_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (REQ_W)
    ) u_tag_fifo (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .push            (issue),
        .push_data       (gnt_id),
        .pop             (pop),
        .full            (fifo_full),
        .empty           (fifo_empty),
        .head            (fifo_head)
    );

    // Results go only to the lane at the FIFO head; that lane's resp_rdy
    // back-pressures the unit, keeping results strictly in issue order.
    always_comb begin
        resp_vld = '0;
        if (intp_out_vld && !fifo_empty) begin
            resp_vld[fifo_head] = 1'b1;
        end
    end

    assign intp_out_rdy = ~fifo_empty & resp_rdy[fifo_head];
    assign pop          = intp_out_vld & intp_out_rdy;
    assign resp_pd      = intp_out_pd;
    assign arb_idle     = ~(|req_vld) & fifo_empty;

    // A result with no owner means the unit and arbiter lost sync; latch it.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            arb_err <= 1'b0;
        end else if (intp_out_vld && fifo_empty) begin
            arb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nvdla_cdp_dp_intp_arb.sv
// Self-checking bench for nvdla_cdp_dp_intp_arb. Random lanes feed the
// arbiter; a behavioural INTP unit model sits on the unit side; a reference
// model of the round-robin/tag rules predicts every handshake signal; and a
// monitor process matches each delivered result against a scoreboard queue.
module tb_nvdla_cdp_dp_intp_arb;
    import nvdla_cdp_dp_intp_arb_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int REQ_W     = 2;
    localparam int TAG_DEPTH = 4;
    localparam int UNIT_CAP  = 4;
    localparam int UNIT_LAT  = 3;

    logic                      nvdla_core_clk = 1'b0;
    logic                      nvdla_core_rstn;
    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ-1:0]        req_rdy;
    logic [NUM_REQ*39-1:0]     req_in0_pd;
    logic [NUM_REQ*38-1:0]     req_in1_pd;
    logic [NUM_REQ*17-1:0]     req_in_pd;
    logic [NUM_REQ*17-1:0]     req_in_scale;
    logic [NUM_REQ*6-1:0]      req_in_shift;
    logic                      intp_in_vld;
    logic                      intp_in_rdy;
    logic [38:0]               intp_in0_pd;
    logic [37:0]               intp_in1_pd;
    logic [16:0]               intp_in_pd;
    logic [16:0]               intp_in_scale;
    logic [5:0]                intp_in_shift;
    logic                      intp_out_vld;
    logic                      intp_out_rdy;
    logic [16:0]               intp_out_pd;
    logic [NUM_REQ-1:0]        resp_vld;
    logic [NUM_REQ-1:0]        resp_rdy;
    logic [16:0]               resp_pd;
    logic                      arb_idle;
    logic                      arb_err;

    typedef struct {
        logic [38:0] in0;
        logic [37:0] in1;
        logic [16:0] pd;
        logic [16:0] scale;
        logic [5:0]  shift;
    } op_t;

    typedef struct {
        int          id;
        logic [16:0] pd;
    } exp_t;

    typedef struct {
        logic [16:0] pd;
        int          due;
    } unit_t;

    op_t                ops [NUM_REQ];
    exp_t               sbq [$];
    int                 tagq [$];
    unit_t              unitq [$];
    int                 pend_iss [NUM_REQ];
    logic [NUM_REQ-1:0] accepted;
    logic [NUM_REQ-1:0] act_mask;
    int                 model_ptr;
    bit                 err_model;
    int                 cyc;
    int                 p_vld;
    int                 p_in_rdy;
    int                 p_resp_rdy;
    bit                 force_out;
    int                 n_cmp;
    int                 n_fail;

    nvdla_cdp_dp_intp_arb #(
        .NUM_REQ   (NUM_REQ),
        .REQ_W     (REQ_W),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .req_vld         (req_vld),
        .req_rdy         (req_rdy),
        .req_in0_pd      (req_in0_pd),
        .req_in1_pd      (req_in1_pd),
        .req_in_pd       (req_in_pd),
        .req_in_scale    (req_in_scale),
        .req_in_shift    (req_in_shift),
        .intp_in_vld     (intp_in_vld),
        .intp_in_rdy     (intp_in_rdy),
        .intp_in0_pd     (intp_in0_pd),
        .intp_in1_pd     (intp_in1_pd),
        .intp_in_pd      (intp_in_pd),
        .intp_in_scale   (intp_in_scale),
        .intp_in_shift   (intp_in_shift),
        .intp_out_vld    (intp_out_vld),
        .intp_out_rdy    (intp_out_rdy),
        .intp_out_pd     (intp_out_pd),
        .resp_vld        (resp_vld),
        .resp_rdy        (resp_rdy),
        .resp_pd         (resp_pd),
        .arb_idle        (arb_idle),
        .arb_err         (arb_err)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    // Interpolation the unit model performs: X0 + ((X1 - X0) * scale) >> shift.
    function automatic logic [16:0] calc(input op_t o);
        longint d;
        longint p;
        int     sh;
        d  = longint'($signed(o.in1)) - longint'($signed(o.in0));
        p  = d * longint'({1'b0, o.scale});
        sh = int'($signed(o.shift));
        if (sh >= 0) p = p >>> sh;
        else         p = p <<< (-sh);
        return o.pd + p[16:0];
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  s;
        o.in0   = 39'({$urandom(), $urandom()});
        o.in1   = 38'({$urandom(), $urandom()});
        o.pd    = 17'($urandom());
        o.scale = 17'($urandom());
        s       = int'($urandom_range(40, 0)) - 20;
        o.shift = 6'(s);
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic packOps();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_in0_pd[i*39 +: 39]   = ops[i].in0;
            req_in1_pd[i*38 +: 38]   = ops[i].in1;
            req_in_pd[i*17 +: 17]    = ops[i].pd;
            req_in_scale[i*17 +: 17] = ops[i].scale;
            req_in_shift[i*6 +: 6]   = ops[i].shift;
        end
    endtask

    // Lanes hold operands until accepted; unit model presents results once due.
    task automatic applyStimulus();
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accepted[i] || !req_vld[i]) begin
                if (act_mask[i] && ($urandom_range(99, 0) < p_vld)) begin
                    req_vld[i] = 1'b1;
                    ops[i]     = rand_op();
                end else begin
                    req_vld[i] = 1'b0;
                end
            end
            resp_rdy[i] = ($urandom_range(99, 0) < p_resp_rdy);
        end
        accepted = '0;
        packOps();
        intp_in_rdy = ($urandom_range(99, 0) < p_in_rdy) && (unitq.size() < UNIT_CAP);
        if (force_out) begin
            intp_out_vld = 1'b1;
            intp_out_pd  = 17'h01234;
        end else if (unitq.size() > 0 && unitq[0].due <= cyc) begin
            intp_out_vld = 1'b1;
            intp_out_pd  = unitq[0].pd;
        end else begin
            intp_out_vld = 1'b0;
            intp_out_pd  = '0;
        end
    endtask

    // Called mid-cycle: predicts all handshakes from the reference rules,
    // then commits what will happen at the coming rising edge.
    task automatic observeCycle();
        int                 exp_gnt;
        int                 head;
        int                 tags;
        int                 j;
        bit                 full_m;
        bit                 any_m;
        bit                 issue_m;
        bit                 pop_m;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [NUM_REQ-1:0] exp_resp;
        op_t                u;

        tags    = tagq.size();
        full_m  = (tags >= TAG_DEPTH);
        any_m   = (req_vld != '0);
        exp_gnt = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (model_ptr + k) % NUM_REQ;
            if (exp_gnt < 0 && req_vld[j]) exp_gnt = j;
        end
        issue_m = (exp_gnt >= 0) && !full_m && intp_in_rdy;
        exp_rdy = '0;
        if (issue_m) exp_rdy[exp_gnt] = 1'b1;
        head     = (tags > 0) ? tagq[0] : -1;
        exp_resp = '0;
        if (intp_out_vld && head >= 0) exp_resp[head] = 1'b1;
        pop_m = intp_out_vld && (head >= 0) && resp_rdy[head];

        checkOutput("req_rdy", 64'(req_rdy), 64'(exp_rdy));
        checkOutput("intp_in_vld", 64'(intp_in_vld), 64'(any_m && !full_m));
        checkOutput("resp_vld", 64'(resp_vld), 64'(exp_resp));
        checkOutput("intp_out_rdy", 64'(intp_out_rdy), 64'((head >= 0) && resp_rdy[head]));
        checkOutput("arb_idle", 64'(arb_idle), 64'(!any_m && tags == 0));
        checkOutput("arb_err", 64'(arb_err), 64'(err_model));
        if (issue_m) begin
            checkOutput("mux_in0", 64'(intp_in0_pd), 64'(ops[exp_gnt].in0));
            checkOutput("mux_in1", 64'(intp_in1_pd), 64'(ops[exp_gnt].in1));
            checkOutput("mux_pd_scale_shift", 64'({intp_in_pd, intp_in_scale, intp_in_shift}),
                        64'({ops[exp_gnt].pd, ops[exp_gnt].scale, ops[exp_gnt].shift}));
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_vld[i] && req_rdy[i]) begin
                checkOutput("no_starve", 64'(pend_iss[i] < NUM_REQ), 64'd1);
                sbq.push_back('{id: i, pd: calc(ops[i])});
                accepted[i] = 1'b1;
                pend_iss[i] = 0;
            end
        end
        if (issue_m) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i != exp_gnt && req_vld[i]) pend_iss[i]++;
            end
        end

        if (intp_in_vld && intp_in_rdy) begin
            u.in0   = intp_in0_pd;
            u.in1   = intp_in1_pd;
            u.pd    = intp_in_pd;
            u.scale = intp_in_scale;
            u.shift = intp_in_shift;
            unitq.push_back('{pd: calc(u), due: cyc + UNIT_LAT});
        end
        if (intp_out_vld && intp_out_rdy && !force_out && unitq.size() > 0) begin
            void'(unitq.pop_front());
        end

        if (intp_out_vld && head < 0) err_model = 1'b1;
        if (pop_m) void'(tagq.pop_front());
        if (issue_m) begin
            tagq.push_back(exp_gnt);
            model_ptr = (exp_gnt + 1) % NUM_REQ;
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(negedge nvdla_core_clk);
            observeCycle();
            @(posedge nvdla_core_clk);
            #1;
            applyStimulus();
        end
    endtask

    // Asserts reset with all inputs quiet and checks the async-cleared outputs.
    task automatic doReset();
        nvdla_core_rstn = 1'b0;
        req_vld      = '0;
        resp_rdy     = '0;
        intp_in_rdy  = 1'b0;
        intp_out_vld = 1'b0;
        intp_out_pd  = '0;
        force_out    = 1'b0;
        #1;
        checkOutput("rst_arb_err", 64'(arb_err), 64'd0);
        checkOutput("rst_arb_idle", 64'(arb_idle), 64'd1);
        checkOutput("rst_intp_in_vld", 64'(intp_in_vld), 64'd0);
        checkOutput("rst_req_rdy", 64'(req_rdy), 64'd0);
        checkOutput("rst_resp_vld", 64'(resp_vld), 64'd0);
        checkOutput("rst_intp_out_rdy", 64'(intp_out_rdy), 64'd0);
        tagq.delete();
        sbq.delete();
        unitq.delete();
        model_ptr = 0;
        err_model = 1'b0;
        accepted  = '0;
        for (int i = 0; i < NUM_REQ; i++) pend_iss[i] = 0;
        repeat (2) @(posedge nvdla_core_clk);
        #1;
        nvdla_core_rstn = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        n          = 0;
        p_vld      = 0;
        p_in_rdy   = 100;
        p_resp_rdy = 100;
        while ((tagq.size() > 0 || sbq.size() > 0 || req_vld != '0) && n < budget) begin
            runCycles(1);
            n++;
        end
        checkOutput("drain_scoreboard_empty", 64'(sbq.size()), 64'd0);
        checkOutput("drain_arb_idle", 64'(arb_idle), 64'd1);
    endtask

    // Monitor: every delivered result must match the oldest outstanding one.
    initial begin
        exp_t e;
        forever begin
            @(negedge nvdla_core_clk);
            if (nvdla_core_rstn) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (resp_vld[i] && resp_rdy[i]) begin
                        if (sbq.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("[TB] FAIL resp_unexpected: lane %0d got 0x%0h, expected no result", i, resp_pd);
                        end else begin
                            e = sbq.pop_front();
                            checkOutput("resp_lane", 64'(i), 64'(e.id));
                            checkOutput("resp_pd", 64'(resp_pd), 64'(e.pd));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        cyc          = 0;
        act_mask     = '1;
        p_vld        = 0;
        p_in_rdy     = 100;
        p_resp_rdy   = 100;
        req_in0_pd   = '0;
        req_in1_pd   = '0;
        req_in_pd    = '0;
        req_in_scale = '0;
        req_in_shift = '0;
        for (int i = 0; i < NUM_REQ; i++) ops[i] = '{default: '0};
        nvdla_core_rstn = 1'b1;
        #2;
        doReset();
        runCycles(3);

        $display("[TB] all lanes busy, unit and lanes always ready");
        p_vld = 100;
        applyStimulus();
        if (req_vld[0]) begin
            ops[0] = '{in0: 39'h0, in1: 38'h100, pd: 17'h00100, scale: 17'h08000, shift: 6'd16};
            packOps();
        end
        runCycles(24);
        repeat (20) begin
            @(negedge nvdla_core_clk);
            checkOutput("steady_intp_in_vld", 64'(intp_in_vld), 64'd1);
            checkOutput("steady_intp_out_rdy", 64'(intp_out_rdy), 64'd1);
            observeCycle();
            @(posedge nvdla_core_clk);
            #1;
            applyStimulus();
        end
        drain(200);

        $display("[TB] lane 2 alone, then lane 1 joins, then random traffic");
        act_mask = 4'b0100;
        p_vld    = 100;
        runCycles(6);
        act_mask = 4'b0110;
        runCycles(10);
        act_mask   = '1;
        p_vld      = 60;
        p_in_rdy   = 70;
        p_resp_rdy = 70;
        runCycles(100);
        drain(300);

        $display("[TB] result back-pressure fills the tag FIFO");
        p_vld      = 100;
        p_in_rdy   = 100;
        p_resp_rdy = 0;
        runCycles(12);
        @(negedge nvdla_core_clk);
        checkOutput("full_intp_in_vld", 64'(intp_in_vld), 64'd0);
        checkOutput("full_req_rdy", 64'(req_rdy), 64'd0);
        observeCycle();
        @(posedge nvdla_core_clk);
        #1;
        applyStimulus();
        p_resp_rdy = 100;
        drain(300);

        $display("[TB] orphan result raises sticky error");
        force_out = 1'b1;
        runCycles(3);
        force_out = 1'b0;
        runCycles(3);
        checkOutput("err_sticky", 64'(arb_err), 64'd1);
        doReset();

        $display("[TB] random traffic after reset");
        act_mask   = '1;
        p_vld      = 70;
        p_in_rdy   = 80;
        p_resp_rdy = 80;
        runCycles(150);
        drain(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
